// File: rtl/featuremap_pkg.sv
// Shared helpers for the featuremap accumulator: stage-count math, saturation limits
// and the leaky ReLU constants.
package featuremap_pkg;

   localparam int LEAKY_MUL   = 26;
   localparam int LEAKY_SHIFT = 8;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // The tree always has at least one registered stage, even for a single channel.
   function automatic int tree_stages(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

   function automatic longint sat_max(input int w);
      return (longint'(1) << (w - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int w);
      return -(longint'(1) << (w - 1));
   endfunction

endpackage

// File: rtl/featuremap_adder_tree.sv
// Registered binary adder tree summing NUM_CH signed channels; each level grows by one bit
// so no intermediate sum can overflow.
module featuremap_adder_tree
   import featuremap_pkg::*;
#(
   parameter int NUM_CH     = 32,
   parameter int DATA_WIDTH = 16,
   localparam int STAGES    = tree_stages(NUM_CH)
) (
   input  logic                           Clk,
   input  logic                           Rst,
   input  logic                           en,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   data_in,
   input  logic                           valid_in,
   output logic [DATA_WIDTH+STAGES-1:0]   sum_out,
   output logic                           valid_out
);

   localparam int LEAVES = 1 << STAGES;
   localparam int TW     = DATA_WIDTH + STAGES;

   logic signed [DATA_WIDTH-1:0] leaf [LEAVES];
   logic signed [TW-1:0]         node [1:LEAVES-1];
   logic [STAGES-1:0]            vld_reg;

   genvar gi;
   generate
      for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
         if (gi < NUM_CH) begin : g_used
            assign leaf[gi] = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
         end else begin : g_pad
            assign leaf[gi] = '0;
         end
      end

      // Heap layout: node 1 is the root, node n feeds from 2n and 2n+1, leaves follow the last node.
      for (gi = 1; gi < LEAVES; gi++) begin : g_node
         localparam int LVL = clog2(gi + 1) - 1;
         localparam int W   = DATA_WIDTH + STAGES - LVL;
         logic signed [W-1:0] a;
         logic signed [W-1:0] b;
         logic signed [W-1:0] sum_reg;

         if (2 * gi >= LEAVES) begin : g_from_leaf
            assign a = W'(leaf[2*gi - LEAVES]);
            assign b = W'(leaf[2*gi + 1 - LEAVES]);
         end else begin : g_from_node
            assign a = W'(node[2*gi]);
            assign b = W'(node[2*gi + 1]);
         end

         always_ff @(posedge Clk) begin
            if (en) sum_reg <= a + b;
         end

         assign node[gi] = TW'(sum_reg);
      end
   endgenerate

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         vld_reg <= '0;
      end else if (en) begin
         vld_reg[0] <= valid_in;
         for (int i = 1; i < STAGES; i++) vld_reg[i] <= vld_reg[i-1];
      end
   end

   assign sum_out   = node[1];
   assign valid_out = vld_reg[STAGES-1];

endmodule

// File: rtl/featuremap_accum.sv
// Channel sum + bias + saturation + optional activation for one output featuremap, with
// row/frame position flags. Define FEATUREMAP_LEAKY_RELU_EN to enable leaky ReLU.
module featuremap_accum
   import featuremap_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int NUM_CH     = 32,
   parameter int IMG_SIZE   = 104,
   parameter int BIAS       = 0
) (
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
   input  logic                         valid_in,
   output logic                         ready_out,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         valid_out,
   input  logic                         ready_in,
   output logic                         row_last,
   output logic                         frame_last
);

   localparam int STAGES = tree_stages(NUM_CH);
   localparam int SW     = DATA_WIDTH + STAGES;
   localparam int BW     = SW + 1;
   localparam int PW     = DATA_WIDTH + 7;
   localparam int CW     = (clog2(IMG_SIZE) < 1) ? 1 : clog2(IMG_SIZE);

   localparam logic signed [DATA_WIDTH-1:0] BIAS_S = DATA_WIDTH'(BIAS);
   localparam logic signed [BW-1:0]         MAX_B  = BW'(sat_max(DATA_WIDTH));
   localparam logic signed [BW-1:0]         MIN_B  = BW'(sat_min(DATA_WIDTH));
   localparam logic [CW-1:0]                LAST   = CW'(IMG_SIZE - 1);

   logic                         en;
   logic signed [SW-1:0]         tree_sum;
   logic                         tree_valid;
   logic signed [BW-1:0]         biased;
   logic signed [DATA_WIDTH-1:0] sat_val;
   logic signed [DATA_WIDTH-1:0] bias_reg;
   logic                         bias_vld_reg;
   logic signed [DATA_WIDTH-1:0] act_val;
   logic [CW-1:0]                col_reg;
   logic [CW-1:0]                row_reg;
   logic                         col_last;
   logic                         row_at_last;

   assign en        = !valid_out || ready_in;
   assign ready_out = en;

   featuremap_adder_tree #(
      .NUM_CH     (NUM_CH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_tree (
      .Clk       (Clk),
      .Rst       (Rst),
      .en        (en),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .sum_out   (tree_sum),
      .valid_out (tree_valid)
   );

   assign biased = BW'(tree_sum) + BW'(BIAS_S);

   always_comb begin
      sat_val = biased[DATA_WIDTH-1:0];
      if (biased > MAX_B)      sat_val = MAX_B[DATA_WIDTH-1:0];
      else if (biased < MIN_B) sat_val = MIN_B[DATA_WIDTH-1:0];
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         bias_vld_reg <= 1'b0;
         bias_reg     <= '0;
      end else if (en) begin
         bias_vld_reg <= tree_valid;
         bias_reg     <= sat_val;
      end
   end

`ifdef FEATUREMAP_LEAKY_RELU_EN
   // Scaled product never exceeds the input magnitude, so truncating back is exact.
   always_comb begin
      act_val = bias_reg;
      if (bias_reg[DATA_WIDTH-1])
         act_val = DATA_WIDTH'((PW'(bias_reg) * PW'(LEAKY_MUL)) >>> LEAKY_SHIFT);
   end
`else
   assign act_val = bias_reg;
`endif

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         valid_out <= 1'b0;
         data_out  <= '0;
      end else if (en) begin
         valid_out <= bias_vld_reg;
         if (bias_vld_reg) data_out <= act_val;
      end
   end

   assign col_last    = (col_reg == LAST);
   assign row_at_last = (row_reg == LAST);
   assign row_last    = valid_out && col_last;
   assign frame_last  = row_last && row_at_last;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         col_reg <= '0;
         row_reg <= '0;
      end else if (valid_out && ready_in) begin
         if (col_last) begin
            col_reg <= '0;
            row_reg <= row_at_last ? '0 : row_reg + 1'b1;
         end else begin
            col_reg <= col_reg + 1'b1;
         end
      end
   end

endmodule
